// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch unit; FETCH_MISALIGN_TRAP_EN adds the FAULT state
package fetch_pkg;
`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, REQ, WRITE, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;
`endif
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: PC register with load mux and +4 incrementer; without FETCH_MISALIGN_TRAP_EN loads are word-aligned
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] load_val,
  input  logic            incr,
  output logic [XLEN-1:0] pc
);
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_load_val;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_load_val = load_val;
`else
  assign w_load_val = load_val & ~XLEN'(3);
`endif
  assign pc = r_pc;
  // PC update: reset, then load, then sequential increment (wraps modulo 2^XLEN)
  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_PC;
    else if (load) r_pc <= w_load_val;
    else if (incr) r_pc <= r_pc + XLEN'(INSTR_BYTES);
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle fetch FSM feeding the instruction register; FETCH_MISALIGN_TRAP_EN enables misaligned-fetch trap
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            pc_load,
  input  logic [XLEN-1:0] pc_in,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_ready,
  output logic [31:0]     instr_out,
  output logic            IRwrite,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_next,
  output logic            busy
`ifdef FETCH_MISALIGN_TRAP_EN
  ,output logic           fetch_fault
`endif
);
  state_t r_state;
  state_t w_state_nxt;
  logic [31:0] r_instr;
  logic [XLEN-1:0] r_pc_out;
  logic [XLEN-1:0] w_pc;
  logic w_pc_load;
  logic w_pc_incr;
  logic w_capture;
  fetch_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .reset(reset),
    .load(w_pc_load),
    .load_val(pc_in),
    .incr(w_pc_incr),
    .pc(w_pc)
  );
`ifdef FETCH_MISALIGN_TRAP_EN
  logic [XLEN-1:0] w_eff_pc;
  assign w_eff_pc = pc_load ? pc_in : w_pc;
  assign fetch_fault = r_state == FAULT;
`endif
  assign mem_req = r_state == REQ;
  assign mem_addr = w_pc;
  assign IRwrite = r_state == WRITE;
  assign busy = r_state != IDLE;
  assign instr_out = r_instr;
  assign pc_out = r_pc_out;
  assign pc_next = w_pc;
  // state register plus instruction buffer and its PC, captured on the memory response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_pc_out <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_instr <= mem_rdata;
        r_pc_out <= w_pc;
      end
    end
  end
  // next-state and PC control; control inputs are honoured only when not busy
  always_comb begin
    w_state_nxt = r_state;
    w_pc_load = 1'b0;
    w_pc_incr = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_pc_load = pc_load;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (fetch_start) w_state_nxt = (w_eff_pc[1:0] != 2'b00) ? FAULT : REQ;
`else
        if (fetch_start) w_state_nxt = REQ;
`endif
      end
      REQ: begin
        w_capture = mem_ready;
        w_pc_incr = mem_ready;
        w_state_nxt = mem_ready ? WRITE : REQ;
      end
      WRITE: w_state_nxt = IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
      FAULT: begin
        w_pc_load = pc_load;
        w_state_nxt = pc_load ? IDLE : FAULT;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import fetch_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fetch_start = 1'b0;
  logic pc_load = 1'b0;
  logic [31:0] pc_in = '0;
  logic mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic mem_ready = 1'b0;
  logic [31:0] instr_out;
  logic IRwrite;
  logic [31:0] pc_out;
  logic [31:0] pc_next;
  logic busy;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_fault;
`endif
  int tests = 0;
  int fails = 0;
  instr_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .fetch_start(fetch_start),
    .pc_load(pc_load),
    .pc_in(pc_in),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .instr_out(instr_out),
    .IRwrite(IRwrite),
    .pc_out(pc_out),
    .pc_next(pc_next),
    .busy(busy)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,.fetch_fault(fetch_fault)
`endif
  );
  always #5 clk = ~clk;
  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    tests++; if (IRwrite !== 1'b0) begin fails++; $display("FAIL reset_irwrite got %b want 0", IRwrite); end
    tests++; if (instr_out !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 0", instr_out); end
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL reset_pc_out got %h want 0", pc_out); end
    tests++; if (pc_next !== 32'h0) begin fails++; $display("FAIL reset_pc_next got %h want 0", pc_next); end
`ifdef FETCH_MISALIGN_TRAP_EN
    tests++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b want 0", fetch_fault); end
`endif
    reset = 1'b0;
  endtask
  task automatic test_basic_fetch;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL basic_req got %b want 1", mem_req); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL basic_addr got %h want 0", mem_addr); end
    tests++; if (IRwrite !== 1'b0) begin fails++; $display("FAIL basic_early_ir got %b want 0", IRwrite); end
    mem_ready = 1'b1;
    mem_rdata = 32'h0050_0093;
    @(negedge clk);
    mem_ready = 1'b0;
    tests++; if (IRwrite !== 1'b1) begin fails++; $display("FAIL basic_ir got %b want 1", IRwrite); end
    tests++; if (instr_out !== 32'h0050_0093) begin fails++; $display("FAIL basic_instr got %h want 00500093", instr_out); end
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL basic_pc_out got %h want 0", pc_out); end
    tests++; if (pc_next !== 32'h4) begin fails++; $display("FAIL basic_pc_next got %h want 4", pc_next); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL basic_req_drop got %b want 0", mem_req); end
    @(negedge clk);
    tests++; if (IRwrite !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL basic_idle got ir=%b busy=%b want 0 0", IRwrite, busy); end
  endtask
  task automatic test_wait_states;
    int pulses = 0;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin fails++; $display("FAIL wait_req[%0d] got req=%b addr=%h want 1 00000004", i, mem_req, mem_addr); end
      if (IRwrite) pulses++;
      if (i == 3) begin mem_ready = 1'b1; mem_rdata = 32'h4020_8133; end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = NOP_INSTR;
    tests++; if (IRwrite !== 1'b1) begin fails++; $display("FAIL wait_ir got %b want 1", IRwrite); end
    tests++; if (instr_out !== 32'h4020_8133) begin fails++; $display("FAIL wait_instr got %h want 40208133", instr_out); end
    tests++; if (pc_out !== 32'h4 || pc_next !== 32'h8) begin fails++; $display("FAIL wait_pc got out=%h next=%h want 4 8", pc_out, pc_next); end
    @(negedge clk);
    if (IRwrite) pulses++;
    tests++; if (pulses !== 0) begin fails++; $display("FAIL wait_extra_ir got %0d extra pulses want 0", pulses); end
    tests++; if (instr_out !== 32'h4020_8133) begin fails++; $display("FAIL wait_instr_hold got %h want 40208133", instr_out); end
  endtask
  task automatic test_pc_load;
    pc_load = 1'b1;
    pc_in = 32'h100;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin fails++; $display("FAIL load_addr got req=%b addr=%h want 1 00000100", mem_req, mem_addr); end
    pc_in = 32'h200;
    @(negedge clk);
    tests++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL load_busy_ignored got %h want 00000100", mem_addr); end
    pc_load = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = NOP_INSTR;
    @(negedge clk);
    mem_ready = 1'b0;
    tests++; if (IRwrite !== 1'b1 || pc_out !== 32'h100) begin fails++; $display("FAIL load_ir got ir=%b pc_out=%h want 1 00000100", IRwrite, pc_out); end
    tests++; if (pc_next !== 32'h104) begin fails++; $display("FAIL load_pc_next got %h want 00000104", pc_next); end
    @(negedge clk);
  endtask
  task automatic test_wrap;
    pc_load = 1'b1;
    pc_in = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_load = 1'b0;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    tests++; if (mem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr got %h want fffffffc", mem_addr); end
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ready = 1'b0;
    tests++; if (pc_next !== 32'h0) begin fails++; $display("FAIL wrap_pc_next got %h want 0", pc_next); end
    tests++; if (pc_out !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc_out got %h want fffffffc", pc_out); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid_fetch;
    pc_load = 1'b1;
    pc_in = 32'h40;
    fetch_start = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
    fetch_start = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin fails++; $display("FAIL rmid_req got req=%b addr=%h want 1 00000040", mem_req, mem_addr); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (mem_req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_idle got req=%b busy=%b want 0 0", mem_req, busy); end
    tests++; if (instr_out !== 32'h0 || pc_next !== 32'h0) begin fails++; $display("FAIL rmid_state got instr=%h pc=%h want 0 0", instr_out, pc_next); end
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ready = 1'b0;
    tests++; if (IRwrite !== 1'b0 || instr_out !== 32'h0) begin fails++; $display("FAIL rmid_late_ready got ir=%b instr=%h want 0 0", IRwrite, instr_out); end
    @(negedge clk);
    tests++; if (IRwrite !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_quiet got ir=%b busy=%b want 0 0", IRwrite, busy); end
  endtask
  task automatic test_misalign;
    pc_load = 1'b1;
    pc_in = 32'h102;
    @(negedge clk);
    pc_load = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    tests++; if (fetch_fault !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL mis_fault got fault=%b busy=%b want 1 1", fetch_fault, busy); end
    tests++; if (mem_req !== 1'b0 || IRwrite !== 1'b0) begin fails++; $display("FAIL mis_noreq got req=%b ir=%b want 0 0", mem_req, IRwrite); end
    @(negedge clk);
    tests++; if (fetch_fault !== 1'b1 || IRwrite !== 1'b0) begin fails++; $display("FAIL mis_hold got fault=%b ir=%b want 1 0", fetch_fault, IRwrite); end
    pc_load = 1'b1;
    pc_in = 32'h104;
    @(negedge clk);
    pc_load = 1'b0;
    tests++; if (fetch_fault !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mis_clear got fault=%b busy=%b want 0 0", fetch_fault, busy); end
    tests++; if (pc_next !== 32'h104) begin fails++; $display("FAIL mis_pc got %h want 00000104", pc_next); end
`else
    tests++; if (pc_next !== 32'h100) begin fails++; $display("FAIL align_pc got %h want 00000100", pc_next); end
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin fails++; $display("FAIL align_addr got req=%b addr=%h want 1 00000100", mem_req, mem_addr); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    tests++; if (IRwrite !== 1'b1 || pc_next !== 32'h104) begin fails++; $display("FAIL align_done got ir=%b pc=%h want 1 00000104", IRwrite, pc_next); end
    @(negedge clk);
`endif
  endtask
  initial begin
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_pc_load();
    test_wrap();
    test_reset_mid_fetch();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
